inst_prefetch_buffer: RTL and testbench
=======================================

// Module: inst_prefetch_buffer
// PURPOSE
//  Instruction prefetch queue between the instruction ROM and the CPU fetch stage.
//  Reads sequential words from a combinational ROM into a DEPTH-entry FIFO of {pc, inst}.
//  Presents the oldest entry to the CPU over a valid/ready handshake.
//  Flushes and restarts on a redirect (branch/jump) from the CPU.
// PARAMETERS
//  DEPTH     4             FIFO entries; power of two, >= 2
//  ADDR_W    32            instruction address width
//  DATA_W    32            instruction word width
//  RESET_PC  32'h00000000  first fetch address after reset
// PORTS
//  clock               in   1              single clock, rising edge
//  reset               in   1              asynchronous, active-high
//  fetch_enable        in   1              permit ROM fetching
//  rom_chip_enable     out  1              ROM read strobe
//  rom_address_output  out  ADDR_W         ROM word address (= fetch_pc)
//  rom_data_input      in   DATA_W         ROM data, combinational, valid same cycle
//  redirect_valid      in   1              flush queue, restart at redirect_pc
//  redirect_pc         in   ADDR_W         new fetch address; bits [1:0] ignored
//  inst_valid          out  1              head entry available
//  inst_ready          in   1              CPU accepts head entry
//  inst_out            out  DATA_W         head instruction
//  inst_pc             out  ADDR_W         head instruction address
//  fill_count          out  clog2(DEPTH)+1 occupied entries
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, fetch_pc=RESET_PC, head=tail=0, count=0.
//   Outputs: rom_chip_enable=0, rom_address_output=RESET_PC, inst_valid=0,
//   inst_out=0, inst_pc=0, fill_count=0. Reset asserted mid-operation discards all entries.
//  FSM, registered states IDLE/FETCH/FULL:
//   IDLE:  -> FETCH if fetch_enable & count<DEPTH; -> FULL if fetch_enable & count==DEPTH.
//   FETCH: -> FULL if push & ~pop & count==DEPTH-1; -> IDLE if ~fetch_enable.
//   FULL:  -> FETCH if pop & fetch_enable; -> IDLE if ~fetch_enable.
//   redirect_valid overrides: next = fetch_enable ? FETCH : IDLE.
//  rom_chip_enable = (state==FETCH) & ~redirect_valid. Invariant: count<DEPTH in FETCH.
//  push = rom_chip_enable: at edge write {fetch_pc, rom_data_input} at tail;
//   tail++ (mod DEPTH); fetch_pc += 4 (wraps 0xFFFFFFFC -> 0x00000000).
//  inst_valid = (count!=0) & ~redirect_valid; pop = inst_valid & inst_ready.
//   pop: head++ (mod DEPTH).
//  count: +1 push only; -1 pop only; unchanged on simultaneous push and pop.
//  Empty: inst_out=0, inst_pc=0. Otherwise both show the head entry combinationally.
//  Redirect (highest priority): at edge head=tail=count=0, fetch_pc={redirect_pc[ADDR_W-1:2],2'b00}.
//   In the redirect cycle, inst_valid=0, rom_chip_enable=0, and no push or pop occurs.
//  Latency: push at cycle N edge -> inst_valid at cycle N+1 when the queue was empty.
//   Throughput: 1 inst/cycle with inst_ready held high.
//  Deasserting fetch_enable stops fetching only. Queued entries stay poppable; fetch_pc is retained.
// TESTING
//  1 Reset; ROM returns data=address; fetch_enable=1 at cycle 0, inst_ready=1
//    -> ce=1 from cycle 1; inst_valid at cycle 2 with pc=0x0/inst=0x0, then 0x4, 0x8 every cycle.
//  2 inst_ready=0 -> after 4 pushes: state FULL, ce=0, fill_count=4, rom_address_output=0x10;
//    one pop -> fill_count=3, ce=1 the next cycle, 0x10 fetched.
//  3 3 entries queued, redirect_valid=1 with redirect_pc=0x100 -> same cycle inst_valid=0, ce=0;
//    next cycle fill_count=0, address 0x100; first delivered inst_pc=0x100.
//  4 redirect_pc=0x00000103 -> fetch restarts at 0x100; redirect with inst_ready=1 pops nothing.
//  5 redirect_pc=0xFFFFFFF8 -> delivered pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
//  6 reset raised between clock edges with 2 entries queued -> outputs zeroed before the next edge;
//    fill_count=0; fetch resumes at RESET_PC after release.

Source files
------------

// File: rtl/inst_prefetch_buffer.sv
// rtl/inst_prefetch_buffer.sv - instruction prefetch queue between ROM and CPU fetch stage
//
// Purpose: fetches sequential words from a combinational ROM into a DEPTH-entry
// FIFO of {pc, inst}. The oldest entry goes to the CPU over a valid/ready
// handshake. A redirect flushes the queue and restarts fetching at a new address.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   fetch_enable          permits ROM fetching; queued entries stay poppable when low
//   rom_chip_enable       ROM read strobe; every strobed cycle pushes one entry
//   rom_address_output    current fetch address
//   rom_data_input        ROM word for rom_address_output, valid in the same cycle
//   redirect_valid/_pc    flush the queue and restart at redirect_pc (word aligned)
//   inst_valid/_ready     head-entry handshake towards the CPU
//   inst_out, inst_pc     head entry, zero while the queue is empty
//   fill_count            number of occupied entries
module inst_prefetch_buffer #(
  parameter int                 DEPTH    = 4,
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fetch_enable,
  output logic                       rom_chip_enable,
  output logic [ADDR_W-1:0]          rom_address_output,
  input  logic [DATA_W-1:0]          rom_data_input,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [DATA_W-1:0]          inst_out,
  output logic [ADDR_W-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]     fill_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   mem_pc_q   [DEPTH];
  logic [DATA_W-1:0]   mem_inst_q [DEPTH];

  logic push;
  logic pop;
  logic empty;

  // The two low redirect address bits are dropped to keep fetches word aligned.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // A redirect cycle is dead: nothing is fetched or delivered while the queue is flushed.
  assign push  = (state_q == S_FETCH) & ~redirect_valid;
  assign empty = (count_q == '0);
  assign pop   = inst_valid & inst_ready;

  assign rom_chip_enable    = push;
  assign rom_address_output = fetch_pc_q;
  assign inst_valid         = ~empty & ~redirect_valid;
  assign inst_out           = empty ? '0 : mem_inst_q[head_q];
  assign inst_pc            = empty ? '0 : mem_pc_q[head_q];
  assign fill_count         = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc_q[tail_q]   <= fetch_pc_q;
      mem_inst_q[tail_q] <= rom_data_input;
    end
  end

  // FETCH is only ever entered with room left, so a strobed fetch always has a slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (redirect_valid) begin
      state_q <= fetch_enable ? S_FETCH : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_enable) begin
            state_q <= (count_q == CNT_W'(DEPTH)) ? S_FULL : S_FETCH;
          end
        end
        S_FETCH: begin
          if (!fetch_enable) begin
            state_q <= S_IDLE;
          end else if (push && !pop && count_q == CNT_W'(DEPTH - 1)) begin
            state_q <= S_FULL;
          end
        end
        S_FULL: begin
          if (!fetch_enable) begin
            state_q <= S_IDLE;
          end else if (pop) begin
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb/tb_inst_prefetch_buffer.sv - self-checking bench for inst_prefetch_buffer
module tb_inst_prefetch_buffer;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic        rom_chip_enable;
  logic [31:0] rom_address_output;
  logic [31:0] rom_data_input;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [2:0]  fill_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rom_xor = 32'h0;

  inst_prefetch_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .fetch_enable(fetch_enable),
    .rom_chip_enable(rom_chip_enable), .rom_address_output(rom_address_output),
    .rom_data_input(rom_data_input), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .fill_count(fill_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ rom_xor;
  endfunction

  assign rom_data_input = rom_word(rom_address_output);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of delivered-to-be words plus the fetch address and
  // whether the fetcher is idle, actively fetching, or stalled on a full queue.
  localparam int M_IDLE = 0, M_FETCH = 1, M_FULL = 2;
  logic [31:0] m_pc[$];
  logic [31:0] m_ins[$];
  logic [31:0] m_fpc  = 32'h0;
  int          m_mode = M_IDLE;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pc.delete(); m_ins.delete();
      m_fpc  = 32'h0;
      m_mode = M_IDLE;
    end else begin
      int  n;
      bit  fetching, deliver, taken;
      n        = m_pc.size();
      fetching = (m_mode == M_FETCH) && !redirect_valid;
      deliver  = (n != 0) && !redirect_valid;
      taken    = deliver && inst_ready;
      if (redirect_valid) begin
        m_pc.delete(); m_ins.delete();
        m_fpc  = {redirect_pc[31:2], 2'b00};
        m_mode = fetch_enable ? M_FETCH : M_IDLE;
      end else begin
        if (taken) begin
          void'(m_pc.pop_front()); void'(m_ins.pop_front());
        end
        if (fetching) begin
          m_pc.push_back(m_fpc); m_ins.push_back(rom_word(m_fpc));
          m_fpc = m_fpc + 32'd4;
        end
        if (!fetch_enable) m_mode = M_IDLE;
        else if (m_mode == M_IDLE) m_mode = (n == DEPTH) ? M_FULL : M_FETCH;
        else if (m_mode == M_FETCH && fetching && !taken && n == DEPTH - 1) m_mode = M_FULL;
        else if (m_mode == M_FULL && taken) m_mode = M_FETCH;
      end
    end
  end

  always @(negedge clock) begin
    bit has;
    has = m_pc.size() != 0;
    check("m_ce",    64'(rom_chip_enable),    64'((m_mode == M_FETCH) && !redirect_valid));
    check("m_addr",  64'(rom_address_output), 64'(m_fpc));
    check("m_valid", 64'(inst_valid),         64'(has && !redirect_valid));
    check("m_inst",  64'(inst_out),           has ? 64'(m_ins[0]) : 64'h0);
    check("m_pc",    64'(inst_pc),            has ? 64'(m_pc[0])  : 64'h0);
    check("m_count", 64'(fill_count),         64'(m_pc.size()));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; fetch_enable = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #3;
    check("rst_ce", 64'(rom_chip_enable), 64'h0);
    check("rst_addr", 64'(rom_address_output), 64'h0);
    check("rst_valid", 64'(inst_valid), 64'h0);
    check("rst_inst", 64'(inst_out), 64'h0);
    check("rst_pc", 64'(inst_pc), 64'h0);
    check("rst_count", 64'(fill_count), 64'h0);
    tick(); tick();

    // Streaming from reset with data = address.
    reset = 1'b0; fetch_enable = 1'b1; inst_ready = 1'b1;
    #1 check("t1_c0_ce", 64'(rom_chip_enable), 64'h0);
    tick();
    check("t1_c1_ce", 64'(rom_chip_enable), 64'h1);
    check("t1_c1_valid", 64'(inst_valid), 64'h0);
    tick();
    check("t1_c2_valid", 64'(inst_valid), 64'h1);
    check("t1_c2_pc", 64'(inst_pc), 64'h0);
    check("t1_c2_inst", 64'(inst_out), 64'h0);
    tick();
    check("t1_c3_pc", 64'(inst_pc), 64'h4);
    tick();
    check("t1_c4_pc", 64'(inst_pc), 64'h8);
    check("t1_c4_count", 64'(fill_count), 64'h1);

    // Fill to FULL with the CPU stalled, then release one entry.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; fetch_enable = 1'b1; inst_ready = 1'b0;
    repeat (5) tick();
    check("t2_full_ce", 64'(rom_chip_enable), 64'h0);
    check("t2_full_count", 64'(fill_count), 64'h4);
    check("t2_full_addr", 64'(rom_address_output), 64'h10);
    check("t2_full_pc", 64'(inst_pc), 64'h0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("t2_pop_count", 64'(fill_count), 64'h3);
    check("t2_pop_ce", 64'(rom_chip_enable), 64'h1);
    check("t2_pop_addr", 64'(rom_address_output), 64'h10);
    tick();
    check("t2_refill_count", 64'(fill_count), 64'h4);
    check("t2_refill_addr", 64'(rom_address_output), 64'h14);

    // Redirect with three entries queued.
    inst_ready = 1'b1;
    tick();
    rom_xor = 32'hDEAD0000;
    check("t3_pre_count", 64'(fill_count), 64'h3);
    redirect_valid = 1'b1; redirect_pc = 32'h100; inst_ready = 1'b0;
    #1;
    check("t3_redir_valid", 64'(inst_valid), 64'h0);
    check("t3_redir_ce", 64'(rom_chip_enable), 64'h0);
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    check("t3_count", 64'(fill_count), 64'h0);
    check("t3_addr", 64'(rom_address_output), 64'h100);
    tick();
    check("t3_first_pc", 64'(inst_pc), 64'h100);
    check("t3_first_inst", 64'(inst_out), 64'hDEAD0100);

    // Misaligned redirect target while the CPU is ready.
    redirect_valid = 1'b1; redirect_pc = 32'h103; inst_ready = 1'b1;
    #1 check("t4_redir_valid", 64'(inst_valid), 64'h0);
    tick();
    redirect_valid = 1'b0;
    check("t4_addr", 64'(rom_address_output), 64'h100);
    check("t4_count", 64'(fill_count), 64'h0);
    tick();
    check("t4_pc0", 64'(inst_pc), 64'h100);
    tick();
    check("t4_pc1", 64'(inst_pc), 64'h104);

    // Address wrap at the top of the space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFF8;
    tick();
    redirect_valid = 1'b0;
    check("t5_addr", 64'(rom_address_output), 64'hFFFFFFF8);
    tick();
    check("t5_pc0", 64'(inst_pc), 64'hFFFFFFF8);
    tick();
    check("t5_pc1", 64'(inst_pc), 64'hFFFFFFFC);
    tick();
    check("t5_pc2", 64'(inst_pc), 64'h0);
    check("t5_inst2", 64'(inst_out), 64'hDEAD0000);

    // Asynchronous reset between edges with two entries queued.
    inst_ready = 1'b0;
    tick();
    check("t6_pre_count", 64'(fill_count), 64'h2);
    #2 reset = 1'b1;
    #1;
    check("t6_count", 64'(fill_count), 64'h0);
    check("t6_valid", 64'(inst_valid), 64'h0);
    check("t6_inst", 64'(inst_out), 64'h0);
    check("t6_pc", 64'(inst_pc), 64'h0);
    check("t6_addr", 64'(rom_address_output), 64'h0);
    tick(); tick();
    reset = 1'b0; fetch_enable = 1'b1; inst_ready = 1'b1;
    tick();
    check("t6_resume_ce", 64'(rom_chip_enable), 64'h1);
    check("t6_resume_addr", 64'(rom_address_output), 64'h0);
    tick();
    check("t6_resume_pc", 64'(inst_pc), 64'h0);

    // Mixed directed pattern: fetch pauses, back-pressure and redirects.
    for (int i = 0; i < 48; i++) begin
      fetch_enable   = !(i inside {[10:16]} || i inside {[36:38]});
      inst_ready     = (i % 3) != 0 && !(i inside {[24:30]});
      redirect_valid = (i == 20) || (i == 33) || (i == 40);
      redirect_pc    = 32'h200 + 32'(i * 4) + 32'(i & 3);
      tick();
    end
    redirect_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
